// File: rtl/my_sys_onchip_ram_pkg.sv
// Shared types and constants for the my_sys on-chip RAM controller.
// DEPTH/BE_W describe the drop-in 128x32 configuration and serve as array defaults.
package my_sys_onchip_ram_pkg;

  typedef enum logic {
    CLEAR,
    READY
  } ram_state_e;

  localparam int unsigned DEPTH = 128;
  localparam int unsigned BE_W  = 4;

  localparam int unsigned READ_LATENCY_MIN = 1;
  localparam int unsigned READ_LATENCY_MAX = 3;

  function automatic bit read_latency_ok(input int unsigned lat);
    return (lat >= READ_LATENCY_MIN) && (lat <= READ_LATENCY_MAX);
  endfunction

endpackage

// File: rtl/my_sys_onchip_ram_array.sv
// Inferred single-port RAM with byte-lane write enables and a registered read port.
module my_sys_onchip_ram_array
  import my_sys_onchip_ram_pkg::*;
#(
  parameter int unsigned DATA_W = BE_W * 8,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                we,
  input  logic                re,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W/8-1:0] be,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata
);

  localparam int unsigned NBE    = DATA_W / 8;
  localparam int unsigned NWORDS = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [NWORDS];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < NBE; i++) begin
        if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  // Read kept directly in the clocked block so it maps onto the RAM output register.
  always_ff @(posedge clk) begin
    if (reset)   rdata_q <= '0;
    else if (re) rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/my_sys_onchip_ram_ctrl.sv
// Avalon-MM slave around the byte-enabled RAM: post-reset clear, pipelined reads,
// clken freeze and reset_req write protection.
module my_sys_onchip_ram_ctrl
  import my_sys_onchip_ram_pkg::*;
#(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned ADDR_W         = 7,
  parameter int unsigned READ_LATENCY   = 1,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                reset_req,
  input  logic [ADDR_W-1:0]   address,
  input  logic                clken,
  input  logic                chipselect,
  input  logic                read,
  input  logic                write,
  input  logic [DATA_W-1:0]   writedata,
  input  logic [DATA_W/8-1:0] byteenable,
  output logic [DATA_W-1:0]   readdata,
  output logic                readdatavalid,
  output logic                waitrequest,
  output logic                init_done
);

  localparam int unsigned NBE       = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam ram_state_e RESET_STATE = CLEAR_ON_RESET ? CLEAR : READY;

  if (!read_latency_ok(READ_LATENCY)) begin : g_bad_latency
    $error("READ_LATENCY must be between 1 and 3");
  end
  if ((DATA_W % 8 != 0) || (DATA_W < 8) || (DATA_W > 128)) begin : g_bad_width
    $error("DATA_W must be a multiple of 8 between 8 and 128");
  end

  ram_state_e              state_q, state_d;
  logic [ADDR_W-1:0]       clr_cnt_q, clr_cnt_d;
  logic                    init_done_q, init_done_d;
  logic [READ_LATENCY-1:0] vld_q, vld_d;

  logic              accept, wr_acc, rd_acc, clearing;
  logic              ram_we, ram_re;
  logic [ADDR_W-1:0] ram_addr;
  logic [NBE-1:0]    ram_be;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  assign waitrequest = !init_done_q || !clken;
  assign accept      = chipselect && (read || write) && !waitrequest;
  assign wr_acc      = accept && write;
  assign rd_acc      = accept && read && !write;
  assign clearing    = (state_q == CLEAR) && clken && !reset;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      CLEAR: begin
        if (clken) begin
          clr_cnt_d = clr_cnt_q + 1'b1;
          if (clr_cnt_q == LAST_ADDR) state_d = READY;
        end
      end
      READY:   state_d = READY;
      default: state_d = RESET_STATE;
    endcase
    // Rising together with the READY transition keeps waitrequest high for exactly DEPTH cycles.
    init_done_d = (state_d == READY);
  end

  always_comb begin
    vld_d = vld_q;
    if (clken) begin
      vld_d[0] = rd_acc;
      for (int unsigned i = 1; i < READ_LATENCY; i++) vld_d[i] = vld_q[i-1];
    end
  end

  always_comb begin
    ram_we    = clearing || (wr_acc && !reset_req && !reset);
    ram_re    = rd_acc && !reset;
    ram_addr  = clearing ? clr_cnt_q : address;
    ram_wdata = clearing ? '0 : writedata;
    ram_be    = clearing ? '1 : byteenable;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RESET_STATE;
      clr_cnt_q   <= '0;
      init_done_q <= 1'b0;
      vld_q       <= '0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      init_done_q <= init_done_d;
      vld_q       <= vld_d;
    end
  end

  my_sys_onchip_ram_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .reset (reset),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .be    (ram_be),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  if (READ_LATENCY > 1) begin : g_pipe
    localparam int unsigned XS = READ_LATENCY - 1;

    logic [DATA_W-1:0] pipe_q [XS];
    logic [DATA_W-1:0] pipe_d [XS];

    // Stages only load alongside their valid bit, so readdata holds between strobes.
    always_comb begin
      pipe_d = pipe_q;
      if (clken && vld_q[0]) pipe_d[0] = ram_rdata;
      for (int unsigned i = 1; i < XS; i++) begin
        if (clken && vld_q[i]) pipe_d[i] = pipe_q[i-1];
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int unsigned i = 0; i < XS; i++) pipe_q[i] <= '0;
      end else begin
        pipe_q <= pipe_d;
      end
    end

    assign readdata = pipe_q[XS-1];
  end else begin : g_direct
    assign readdata = ram_rdata;
  end

  assign readdatavalid = vld_q[READ_LATENCY-1];
  assign init_done     = init_done_q;

endmodule

// File: tb/tb_my_sys_onchip_ram_ctrl.sv
// Scoreboard bench: driver updates a word-array model and queues expected reads;
// a monitor pops and compares whenever readdatavalid is presented.
module tb_my_sys_onchip_ram_ctrl;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 7;
  localparam int unsigned LAT   = 3;
  localparam int unsigned WORDS = 128;

  logic          clk;
  logic          reset;
  logic          reset_req;
  logic [AW-1:0] address;
  logic          clken;
  logic          chipselect;
  logic          read;
  logic          write;
  logic [DW-1:0] writedata;
  logic [3:0]    byteenable;
  logic [DW-1:0] readdata;
  logic          readdatavalid;
  logic          waitrequest;
  logic          init_done;

  my_sys_onchip_ram_ctrl #(
    .DATA_W         (DW),
    .ADDR_W         (AW),
    .READ_LATENCY   (LAT),
    .CLEAR_ON_RESET (1'b1)
  ) u_dut (
    .clk           (clk),
    .reset         (reset),
    .reset_req     (reset_req),
    .address       (address),
    .clken         (clken),
    .chipselect    (chipselect),
    .read          (read),
    .write         (write),
    .writedata     (writedata),
    .byteenable    (byteenable),
    .readdata      (readdata),
    .readdatavalid (readdatavalid),
    .waitrequest   (waitrequest),
    .init_done     (init_done)
  );

  typedef struct {
    logic [31:0] data;
    int unsigned due;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] model [WORDS];
  logic [31:0] last_data;
  int          total = 0;
  int          bad   = 0;
  int unsigned edges = 0;
  bit          model_ready = 1'b0;
  bit          mon_ce, mon_rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: edges counts clken-high clock edges, which is what read latency is measured in.
  initial begin
    forever begin
      @(posedge clk);
      mon_ce  = clken;
      mon_rst = reset;
      #1;
      if (mon_ce) edges++;
      if (mon_rst) begin
        exp_q.delete();
        check("rdv_in_reset", 32'(readdatavalid), 32'd0);
      end else if (readdatavalid && mon_ce) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_rdv: got 1 expected 0 at %0t", $time);
        end else begin
          mon_e = exp_q.pop_front();
          check("read_data", readdata, mon_e.data);
          check("read_latency", edges, mon_e.due);
          last_data = mon_e.data;
        end
      end else if (readdatavalid) begin
        check("rdv_hold_data", readdata, last_data);
      end else if (mon_ce && exp_q.size() != 0 && exp_q[0].due <= edges) begin
        mon_e = exp_q.pop_front();
        total++;
        bad++;
        $display("FAIL missing_rdv: got 0 expected 1 (data %h) at %0t", mon_e.data, $time);
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  // One bus cycle, entered and left at a falling edge.
  task automatic cyc(input bit cs, input bit rd, input bit wr, input logic [AW-1:0] a,
                     input logic [31:0] wd, input logic [3:0] be, input bit rr, input bit ce);
    chipselect = cs;
    read       = rd;
    write      = wr;
    address    = a;
    writedata  = wd;
    byteenable = be;
    reset_req  = rr;
    clken      = ce;
    #1;
    check("waitrequest", 32'(waitrequest), 32'(!(model_ready && ce)));
    if (cs && (rd || wr) && !waitrequest) begin
      if (wr) begin
        if (!rr) begin
          for (int i = 0; i < 4; i++) if (be[i]) model[a][i*8 +: 8] = wd[i*8 +: 8];
        end
      end else begin
        exp_q.push_back('{data: model[a], due: edges + LAT});
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1);
  endtask

  task automatic rd_op(input logic [AW-1:0] a);
    cyc(1'b1, 1'b1, 1'b0, a, '0, '0, 1'b0, 1'b1);
  endtask

  task automatic wr_op(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be, input bit rr);
    cyc(1'b1, 1'b0, 1'b1, a, d, be, rr, 1'b1);
  endtask

  task automatic do_reset(input int unsigned n);
    reset       = 1'b1;
    chipselect  = 1'b0;
    read        = 1'b0;
    write       = 1'b0;
    clken       = 1'b1;
    model_ready = 1'b0;
    repeat (n) @(negedge clk);
    check("rst_waitrequest", 32'(waitrequest), 32'd1);
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_rdv", 32'(readdatavalid), 32'd0);
    check("rst_readdata", readdata, 32'd0);
  endtask

  // Runs the clear after reset release; returns the number of clken-high cycles seen.
  task automatic run_clear(input bit stall, input int unsigned stop_at, output int unsigned n);
    n = 0;
    for (int unsigned g = 0; g < 1000 && !init_done && n < stop_at; g++) begin
      clken = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      check("clear_waitrequest", 32'(waitrequest), 32'd1);
      @(posedge clk);
      if (clken) n++;
      @(negedge clk);
    end
  endtask

  task automatic finish_clear(input bit stall);
    int unsigned n;
    reset = 1'b0;
    run_clear(stall, 1000, n);
    check("clear_cycles", n, 32'd128);
    check("init_done_after_clear", 32'(init_done), 32'd1);
    for (int i = 0; i < int'(WORDS); i++) model[i] = '0;
    model_ready = 1'b1;
  endtask

  task automatic drain();
    for (int unsigned i = 0; i < 30 && exp_q.size() != 0; i++) idle(1);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic random_ops(input int unsigned n);
    int unsigned kind;
    for (int unsigned i = 0; i < n; i++) begin
      kind = $urandom_range(0, 9);
      cyc(kind != 0, kind inside {[1:4], 8}, kind inside {[5:8]},
          ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 127)) : AW'($urandom_range(0, 15)),
          32'($urandom), 4'($urandom_range(0, 15)), $urandom_range(0, 7) == 0,
          $urandom_range(0, 4) != 0);
    end
  endtask

  initial begin
    int unsigned n;
    reset = 1'b1; reset_req = 1'b0; clken = 1'b1; chipselect = 1'b0;
    read = 1'b0; write = 1'b0; address = '0; writedata = '0; byteenable = '0;
    last_data = '0;
    @(negedge clk);
    do_reset(3);
    finish_clear(1'b0);

    rd_op(7'd0);
    rd_op(7'd64);
    rd_op(7'd127);
    drain();

    wr_op(7'd5, 32'hAABBCCDD, 4'b1111, 1'b0);
    wr_op(7'd5, 32'h11223344, 4'b0101, 1'b0);
    rd_op(7'd5);
    drain();

    wr_op(7'd9, 32'hDEADBEEF, 4'b1111, 1'b0);
    wr_op(7'd9, 32'h00000000, 4'b1111, 1'b1);
    rd_op(7'd9);
    drain();

    wr_op(7'd1, 32'h01010101, 4'b1111, 1'b0);
    wr_op(7'd2, 32'h02020202, 4'b1111, 1'b0);
    wr_op(7'd3, 32'h03030303, 4'b1111, 1'b0);
    rd_op(7'd1);
    rd_op(7'd2);
    rd_op(7'd3);
    drain();

    wr_op(7'd7, 32'hCAFEF00D, 4'b1111, 1'b0);
    rd_op(7'd7);
    for (int unsigned i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 7'd3, '0, '0, 1'b0, 1'b0);
    drain();

    cyc(1'b1, 1'b1, 1'b1, 7'd11, 32'h5A5A5A5A, 4'b1111, 1'b0, 1'b1);
    rd_op(7'd11);
    drain();

    random_ops(400);
    drain();

    rd_op(7'd5);
    do_reset(2);
    reset = 1'b0;
    run_clear(1'b0, 50, n);
    check("partial_clear_cycles", n, 32'd50);
    do_reset(2);
    finish_clear(1'b1);

    rd_op(7'd5);
    rd_op(7'd9);
    random_ops(300);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/my_sys_onchip_ram_ctrl.md
# my_sys_onchip_ram_ctrl

Parametrised next-generation on-chip memory for the `my_sys` Platform Designer system: an Avalon-MM slave wrapping a single-port, byte-enabled RAM of configurable width and depth. It adds a configurable pipelined read latency with `readdatavalid`, a `waitrequest`-gated post-reset clear sequence, and write protection during `reset_req`. It sits on the system interconnect in the same slot as the fixed 128×32 on-chip memory and serves as a drop-in upgrade.

## Interface
- `DATA_W`, 32, data width in bits; must be a multiple of 8, from 8 to 128.
- `ADDR_W`, 7, word address width; depth `DEPTH = 2**ADDR_W`.
- `READ_LATENCY`, 1, read pipeline depth, from 1 to 3.
- `CLEAR_ON_RESET`, 1, when 1, zero every word after reset.

- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `reset_req`  in  1  early reset warning; blocks array writes while high.
- `address`  in  ADDR_W  word address.
- `clken`  in  1  clock enable; low freezes the slave.
- `chipselect`  in  1  slave select.
- `read`  in  1  read request.
- `write`  in  1  write request.
- `writedata`  in  DATA_W  write data.
- `byteenable`  in  DATA_W/8  byte-lane write mask.
- `readdata`  out  DATA_W  read data; valid when `readdatavalid`=1.
- `readdatavalid`  out  1  one-cycle strobe per accepted read.
- `waitrequest`  out  1  slave not accepting transfers.
- `init_done`  out  1  high once the clear sequence has finished.

## Operation
- FSM states: CLEAR and READY. Reset enters CLEAR if `CLEAR_ON_RESET`=1, otherwise READY.
- CLEAR:
  - A clear counter runs 0..DEPTH-1 and writes all-zero, all lanes, one word per `clken`-high cycle.
  - The counter holds when `clken`=0.
  - After writing DEPTH-1 the FSM goes to READY.
  - `waitrequest`=1 and `init_done`=0 throughout.
- READY: `init_done`=1. `waitrequest` = !`clken`.
- Accept condition: `chipselect` & (`read`|`write`) & !`waitrequest`.
- Write: updates only the lanes with `byteenable`[i]=1. It is suppressed when `reset_req`=1: the transfer is still accepted, but the array is unchanged.
- Read and write asserted together: treat as a write only. No `readdatavalid` is produced.
- `reset_req` does not block reads or the clear sequence.
- Outside valid strobes, `readdata` holds the last returned value.
- Reset values: `readdata`=0, `readdatavalid`=0, `waitrequest`=1, `init_done`=0. The array contents are not reset, except through CLEAR.
- Reset during a clear restarts the counter at 0.
- Reset with reads in flight discards them; no `readdatavalid` follows.

## Timing
- A read accepted at edge k has `readdatavalid`=1 and the data sampled at edge k+READ_LATENCY.
- Back-to-back reads pipeline at one per cycle. Strobes come out in order with no gaps.
- When `clken`=0, all pipeline stages (data and valid) hold, and any strobe is extended until `clken` returns.
- Read-after-write: a write at edge k followed by a read of the same address accepted at edge k+1 returns the new data.
- Clear duration: exactly DEPTH `clken`-high cycles after reset deasserts. `init_done` rises on the edge after the last clear write.
- With `CLEAR_ON_RESET`=0, `waitrequest` falls on the first cycle after reset deasserts (if `clken`=1).

## Structure
- Package `my_sys_onchip_ram_pkg` holds:
  - the state enum `ram_state_e` {CLEAR, READY};
  - the localparams `DEPTH` and `BE_W`;
  - the `READ_LATENCY` bounds check.
- Sub-module `my_sys_onchip_ram_array` is an inferred single-port RAM with byte enables and a 1-cycle registered read.
- The top level holds the FSM, the clear counter, the extra read stages (READ_LATENCY-1 of them) and the valid shift register.

## Test plan
- Clear after reset: DATA_W=32, ADDR_W=7, CLEAR_ON_RESET=1. Deassert reset and hold `clken`=1 → `waitrequest` high for 128 cycles, then `init_done`=1. Reads of addresses 0, 64 and 127 return 0x00000000.
- Byte enables: write 0xAABBCCDD at address 5 with be=4'b1111, then 0x11223344 with be=4'b0101, then read → 0xAA22CC44.
- Latency: READ_LATENCY=3. Back-to-back reads of addresses 1, 2, 3 accepted at edges k..k+2 → `readdatavalid` at edges k+3..k+5, with the data in order.
- `clken` stall: READ_LATENCY=2. Drop `clken` for 4 cycles one cycle after a read is accepted → strobe delayed by 4 cycles, data correct, and `waitrequest`=1 during the stall.
- `reset_req`: write 0xDEADBEEF at address 9, then write 0x0 at address 9 with `reset_req`=1, then read → 0xDEADBEEF.
- Reset mid-operation: assert reset at clear count 50 → the counter restarts and `init_done` rises 128 cycles after release. A read in flight at reset never produces `readdatavalid`.
